// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: FSM states, register-zero
// constant, the strobe bundle and the saturating-increment helper.
`ifndef MIPS_PKG_SV
`define MIPS_PKG_SV

// Saturating +1: holds at all-ones instead of wrapping.
`define SAT_INC(c) ((&(c)) ? (c) : ((c) + 1'b1))

package mips_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic pc_sel_br;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } strobes_t;

endpackage

`endif

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the ID instruction.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_use_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_wreg,
    output logic       lu_hazard
);

    // $zero never carries a real dependency, so a load targeting it never stalls.
    assign lu_hazard = EX_MemRead && (EX_wreg != REG_ZERO) &&
                       ((EX_wreg == ID_rs) || (ID_use_rt && (EX_wreg == ID_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with timeout,
// taken-branch flush, load-use bubble, plus saturating stall/flush counters.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_wreg,
    input  logic             MEM_Branch,
    input  logic             MEM_zero,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_br,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    logic [0:0]      state, state_nxt;
    logic [WC_W-1:0] wait_ctr;
    logic            lu_hazard, br_taken, mem_req, timeout, mem_stall, br_event;
    strobes_t        stb;

    hazard_detect u_hazard_detect (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_use_rt  (ID_use_rt),
        .EX_MemRead (EX_MemRead),
        .EX_wreg    (EX_wreg),
        .lu_hazard  (lu_hazard)
    );

    assign br_taken = MEM_Branch & MEM_zero;
    assign mem_req  = MEM_MemRead | MEM_MemWrite;
    assign timeout  = (state == ST_MEM_WAIT) && !dmem_ready && (wait_ctr == WC_W'(WAIT_MAX));
    // A timeout breaks the freeze: the access is abandoned and the pipeline moves on.
    assign mem_stall = !dmem_ready &&
                       (((state == ST_RUN) && mem_req) || ((state == ST_MEM_WAIT) && !timeout));
    assign br_event  = !rst && !mem_stall && br_taken;
    assign state_nxt = mem_stall ? ST_MEM_WAIT : ST_RUN;

    always_comb begin
        stb = '0;
        stb.pc_write     = 1'b1;
        stb.if_id_write  = 1'b1;
        stb.ex_mem_write = 1'b1;
        if (rst) begin
            stb.pc_write     = 1'b0;
            stb.if_id_write  = 1'b0;
            stb.ex_mem_write = 1'b0;
            stb.if_id_flush  = 1'b1;
            stb.id_ex_flush  = 1'b1;
            stb.ex_mem_flush = 1'b1;
            stb.mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            stb.pc_write     = 1'b0;
            stb.if_id_write  = 1'b0;
            stb.ex_mem_write = 1'b0;
            stb.mem_wb_flush = 1'b1;
        end else begin
            // A taken branch squashes the ID instruction, so its load-use stall is moot.
            if (br_taken) begin
                stb.pc_sel_br    = 1'b1;
                stb.if_id_flush  = 1'b1;
                stb.id_ex_flush  = 1'b1;
                stb.ex_mem_flush = 1'b1;
            end else if (lu_hazard) begin
                stb.pc_write    = 1'b0;
                stb.if_id_write = 1'b0;
                stb.id_ex_flush = 1'b1;
            end
            if (timeout) stb.mem_wb_flush = 1'b1;
        end
    end

    assign pc_write     = stb.pc_write;
    assign pc_sel_br    = stb.pc_sel_br;
    assign if_id_write  = stb.if_id_write;
    assign if_id_flush  = stb.if_id_flush;
    assign id_ex_flush  = stb.id_ex_flush;
    assign ex_mem_write = stb.ex_mem_write;
    assign ex_mem_flush = stb.ex_mem_flush;
    assign mem_wb_flush = stb.mem_wb_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_ctr    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_ctr <= mem_stall ? (wait_ctr + 1'b1) : '0;
            if (timeout)       mem_timeout <= 1'b1;
            if (!stb.pc_write) stall_cnt   <= `SAT_INC(stall_cnt);
            if (br_event)      flush_cnt   <= `SAT_INC(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, branch, memory wait, timeout, saturation.
module tb_pipe_hazard_ctrl;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_rs, ID_rt, EX_wreg;
    logic          ID_use_rt, EX_MemRead, MEM_Branch, MEM_zero, MEM_MemRead, MEM_MemWrite, dmem_ready;
    logic          pc_write, pc_sel_br, if_id_write, if_id_flush, id_ex_flush;
    logic          ex_mem_write, ex_mem_flush, mem_wb_flush, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    stb;

    int checks   = 0;
    int failures = 0;

    // {pc_write, pc_sel_br, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush}
    localparam logic [7:0] S_RST = 8'b0001_1011;
    localparam logic [7:0] S_DEF = 8'b1010_0100;
    localparam logic [7:0] S_LU  = 8'b0000_1100;
    localparam logic [7:0] S_BR  = 8'b1111_1110;
    localparam logic [7:0] S_MW  = 8'b0000_0001;
    localparam logic [7:0] S_TO  = 8'b1010_0101;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_MAX(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rt(ID_use_rt),
        .EX_MemRead(EX_MemRead), .EX_wreg(EX_wreg), .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_sel_br(pc_sel_br), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign stb = {pc_write, pc_sel_br, if_id_write, if_id_flush, id_ex_flush,
                  ex_mem_write, ex_mem_flush, mem_wb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at negedge; strobes are checked shortly after, then one clock passes.
    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {24'd0, stb}, {24'd0, exp});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rt = 1'b0; EX_MemRead = 1'b0; EX_wreg = 5'd0;
        MEM_Branch = 1'b0; MEM_zero = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
        dmem_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        step("rst_c0", S_RST);
        step("rst_c1", S_RST);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);

        rst = 1'b0;
        step("idle", S_DEF);

        // lw $t0 in EX, ID reads rs=$t0
        EX_MemRead = 1'b1; EX_wreg = 5'd8; ID_rs = 5'd8;
        step("lu_rs", S_LU);
        idle_inputs();
        step("lu_after", S_DEF);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        EX_MemRead = 1'b1; EX_wreg = 5'd0; ID_rs = 5'd0;
        step("lu_reg0", S_DEF);
        EX_wreg = 5'd8; ID_rs = 5'd3; ID_rt = 5'd8; ID_use_rt = 1'b0;
        step("lu_rt_unused", S_DEF);
        ID_use_rt = 1'b1;
        step("lu_rt_used", S_LU);
        chk("lu2_stall_cnt", 32'(stall_cnt), 32'd2);

        // taken branch with a load-use present: branch wins
        ID_rs = 5'd8; MEM_Branch = 1'b1; MEM_zero = 1'b1;
        step("br_over_lu", S_BR);
        MEM_zero = 1'b0;
        EX_MemRead = 1'b0;
        step("br_not_taken", S_DEF);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd2);
        idle_inputs();

        // 3-cycle memory wait
        MEM_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("mw3_%0d", i), S_MW);
        dmem_ready = 1'b1;
        step("mw3_done", S_DEF);
        MEM_MemRead = 1'b0;
        step("mw3_idle", S_DEF);
        chk("mw3_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("mw3_timeout", 32'(mem_timeout), 32'd0);

        // dmem_ready held low 20 cycles: 16 frozen, then forced release
        MEM_MemRead = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step($sformatf("mw_to_%0d", i), S_MW);
        step("timeout_release", S_TO);
        MEM_MemRead = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("post_to_%0d", i), S_DEF);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_stall_cnt", 32'(stall_cnt), 32'd21);

        // memory wait outranks a taken branch; branch fires once the store completes
        MEM_MemWrite = 1'b1; MEM_Branch = 1'b1; MEM_zero = 1'b1;
        step("mw_over_br", S_MW);
        dmem_ready = 1'b1;
        step("br_after_mw", S_BR);
        idle_inputs();
        step("idle2", S_DEF);
        chk("mwbr_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("mwbr_stall_cnt", 32'(stall_cnt), 32'd22);
        chk("to_still_sticky", 32'(mem_timeout), 32'd1);

        // sustained load-use pushes stall_cnt past its 5-bit ceiling
        EX_MemRead = 1'b1; EX_wreg = 5'd9; ID_rs = 5'd9;
        for (int i = 0; i < 12; i++) step($sformatf("lu_sat_%0d", i), S_LU);
        idle_inputs();
        step("sat_idle", S_DEF);
        chk("stall_saturated", 32'(stall_cnt), 32'd31);

        rst = 1'b1;
        step("rst2", S_RST);
        rst = 1'b0;
        step("rst2_idle", S_DEF);
        chk("rst2_timeout", 32'(mem_timeout), 32'd0);
        chk("rst2_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst2_flush_cnt", 32'(flush_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
